hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
Central stall/flush controller for the 5-stage pipeline. Each cycle it decides whether the PC and IF/ID register advance, whether IF/ID is flushed on a taken beq, and whether a bubble is injected into ID/EX. It detects load-use hazards and sequences a fixed-latency multiply/divide unit (MDU) with an internal busy timer. It also keeps saturating stall and flush performance counters. It sits beside the pipeline registers and drives their enable/flush inputs.

Parameters:
MDU_LATENCY, 4, MDU cycles from issue to result available (legal range 2..15)
REG_W, 5, register-address width
CNT_W, 16, performance-counter width

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
id_rs  in  REG_W  rs field of instruction in ID
id_rt  in  REG_W  rt field of instruction in ID
id_uses_rt  in  1  ID instruction reads rt as a source
id_mdu_use  in  1  ID instruction reads the HI/LO (MDU) result
ex_mem_read  in  1  instruction in EX is a load
ex_rt  in  REG_W  destination of the load in EX
beq_taken  in  1  branch in ID resolved taken (ID-stage comparator)
mdu_start  in  1  MDU operation issuing from EX this cycle
pc_write  out  1  PC load enable
if_id_write  out  1  IF/ID load enable
if_id_flush  out  1  zero IF/ID on the next edge
id_ex_bubble  out  1  load a NOP into ID/EX on the next edge
mdu_busy  out  1  MDU result not yet available (registered)
stall_cycles  out  CNT_W  count of stall cycles
flush_cycles  out  CNT_W  count of flush cycles

Behaviour:
- Reset (sync): state IDLE, timer 0, mdu_busy 0, both counters 0. While reset is high: pc_write=0, if_id_write=0, if_id_flush=0, id_ex_bubble=0. Reset mid-MDU abandons the operation; nothing is retained.
- load_hz (comb) = ex_mem_read && ex_rt!=0 && (ex_rt==id_rs || (id_uses_rt && ex_rt==id_rt)).
- mdu_hz (comb) = id_mdu_use && mdu_busy.
- stall = load_hz || mdu_hz.
- On stall: pc_write=0, if_id_write=0, id_ex_bubble=1, if_id_flush=0.
- Stall overrides beq_taken. The branch operands may be stale, so the branch re-resolves on the next cycle.
- No stall and beq_taken: pc_write=1, if_id_write=1, if_id_flush=1, id_ex_bubble=0.
- Otherwise: pc_write=1, if_id_write=1, others 0.
- All four control outputs are combinational, with zero-cycle latency from the inputs.
- Load-use stall lasts exactly one cycle, because the load then moves on to MEM.
- FSM states are IDLE and BUSY.
  - IDLE + mdu_start: go to BUSY, timer=MDU_LATENCY-1.
  - BUSY: timer decrements each cycle. When timer==1 and there is no mdu_start, go to IDLE next edge with timer=0.
  - mdu_busy=1 exactly when state==BUSY, so busy holds for MDU_LATENCY-1 cycles after the issue edge.
  - BUSY + mdu_start (back-to-back issue): reload timer=MDU_LATENCY-1 and stay in BUSY. Restart wins over expiry in the same cycle.
- stall_cycles increments on every non-reset cycle with stall=1.
- flush_cycles increments on every non-reset cycle with if_id_flush=1.
- Both counters saturate at all-ones and never wrap.

Decomposition:
- Package hazard_ctrl_pkg holds:
  - the state enum (IDLE, BUSY);
  - the REG_ZERO constant;
  - a function fn_load_use(ex_mem_read, ex_rt, id_rs, id_rt, id_uses_rt).
- One sub-module, mdu_busy_timer, holds the FSM, the down-counter and mdu_busy, with ports clk, reset, start, busy. The top level holds the hazard logic, the output mux and the counters.

Test Plan:
- Load-use hit: ex_mem_read=1, ex_rt=5, id_rs=5 -> for 1 cycle pc_write=0, if_id_write=0, id_ex_bubble=1; stall_cycles 0->1. Next cycle ex_mem_read=0 gives normal flow.
- $zero and rt masking: ex_rt=0=id_rs -> no stall. ex_rt=7=id_rt with id_uses_rt=0 -> no stall; with id_uses_rt=1 -> stall.
- Taken branch: beq_taken=1, no hazards -> if_id_flush=1, pc_write=1, id_ex_bubble=0; flush_cycles 0->1.
- Branch vs load-use in the same cycle -> stall outputs asserted, if_id_flush=0. Next cycle with beq_taken=1 -> flush.
- MDU with MDU_LATENCY=4: mdu_start at cycle 0 -> mdu_busy=1 in cycles 1-3 and 0 at cycle 4. id_mdu_use held high stalls cycles 1-3 (3 stall cycles). mdu_start again at cycle 2 extends busy through cycle 5.
- Reset and saturation: assert reset while BUSY -> mdu_busy=0 next cycle and counters cleared. With CNT_W=4, hold load_hz for 20 cycles -> stall_cycles stops at 15.

Source files
------------

// File: rtl/hazard_ctrl_pkg.sv
// Shared types and helpers for the pipeline hazard controller.
// Register addresses are zero-extended to a fixed width before entering the helper.
package hazard_ctrl_pkg;

    localparam int REG_ADDR_MAX = 32;
    localparam int TIMER_W      = 4;

    typedef logic [REG_ADDR_MAX-1:0] reg_addr_t;

    localparam reg_addr_t REG_ZERO = '0;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_BUSY = 1'b1;

    typedef enum logic [0:0] {
        IDLE = S_IDLE,
        BUSY = S_BUSY
    } mdu_state_e;

    // A load into $zero never creates a real dependency.
    function automatic logic fn_load_use(
        input logic      ex_mem_read,
        input reg_addr_t ex_rt,
        input reg_addr_t id_rs,
        input reg_addr_t id_rt,
        input logic      id_uses_rt
    );
        return ex_mem_read && (ex_rt != REG_ZERO) &&
               ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
    endfunction

endpackage

// File: rtl/hazard_ctrl_mdu_busy_timer.sv
// Tracks the in-flight multiply/divide operation; busy is high while the
// result is not yet available and a new issue restarts the countdown.
module mdu_busy_timer
    import hazard_ctrl_pkg::*;
#(
    parameter int MDU_LATENCY = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    output logic busy
);

    localparam logic [TIMER_W-1:0] RELOAD = TIMER_W'(MDU_LATENCY - 1);

    mdu_state_e         state;
    logic [TIMER_W-1:0] timer;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            timer <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= BUSY;
                        timer <= RELOAD;
                    end
                end
                BUSY: begin
                    // A back-to-back issue takes priority over expiry.
                    if (start) begin
                        timer <= RELOAD;
                    end else if (timer == TIMER_W'(1)) begin
                        state <= IDLE;
                        timer <= '0;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    timer <= '0;
                end
            endcase
        end
    end

    assign busy = (state == BUSY);

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/flush controller: drives PC and pipeline-register enables from
// load-use and MDU hazards, flushes IF/ID on taken branches, counts events.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int MDU_LATENCY = 4,
    parameter int REG_W       = 5,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rt,
    input  logic             id_mdu_use,
    input  logic             ex_mem_read,
    input  logic [REG_W-1:0] ex_rt,
    input  logic             beq_taken,
    input  logic             mdu_start,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             if_id_flush,
    output logic             id_ex_bubble,
    output logic             mdu_busy,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_cycles
);

    logic load_hz;
    logic mdu_hz;
    logic stall;

    mdu_busy_timer #(
        .MDU_LATENCY(MDU_LATENCY)
    ) u_timer (
        .clk  (clk),
        .reset(reset),
        .start(mdu_start),
        .busy (mdu_busy)
    );

    assign load_hz = fn_load_use(ex_mem_read, reg_addr_t'(ex_rt), reg_addr_t'(id_rs),
                                 reg_addr_t'(id_rt), id_uses_rt);
    assign mdu_hz  = id_mdu_use && mdu_busy;
    assign stall   = load_hz || mdu_hz;

    // A stall suppresses the flush: branch operands may be stale and re-resolve.
    always_comb begin
        pc_write     = 1'b0;
        if_id_write  = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        if (!reset) begin
            if (stall) begin
                id_ex_bubble = 1'b1;
            end else begin
                pc_write    = 1'b1;
                if_id_write = 1'b1;
                if_id_flush = beq_taken;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cycles <= '0;
            flush_cycles <= '0;
        end else begin
            if (stall && (stall_cycles != '1)) begin
                stall_cycles <= stall_cycles + 1'b1;
            end
            if (if_id_flush && (flush_cycles != '1)) begin
                flush_cycles <= flush_cycles + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a behavioural model.
module tb_hazard_ctrl;

    localparam int REG_W = 5;
    localparam int LAT   = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic [REG_W-1:0] id_rs, id_rt, ex_rt;
    logic             id_uses_rt, id_mdu_use, ex_mem_read, beq_taken, mdu_start;

    logic        pc_write_a, if_id_write_a, if_id_flush_a, id_ex_bubble_a, mdu_busy_a;
    logic [15:0] stall_cycles_a, flush_cycles_a;
    logic        pc_write_b, if_id_write_b, if_id_flush_b, id_ex_bubble_b, mdu_busy_b;
    logic [3:0]  stall_cycles_b, flush_cycles_b;

    int n_tests = 0;
    int n_fail  = 0;

    // model state
    bit model_on  = 0;
    int cyc       = 0;
    int busy_until = -1;
    int stall_cnt = 0;
    int flush_cnt = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(.MDU_LATENCY(LAT), .REG_W(REG_W), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .id_mdu_use(id_mdu_use), .ex_mem_read(ex_mem_read), .ex_rt(ex_rt),
        .beq_taken(beq_taken), .mdu_start(mdu_start), .pc_write(pc_write_a),
        .if_id_write(if_id_write_a), .if_id_flush(if_id_flush_a),
        .id_ex_bubble(id_ex_bubble_a), .mdu_busy(mdu_busy_a),
        .stall_cycles(stall_cycles_a), .flush_cycles(flush_cycles_a)
    );

    hazard_ctrl #(.MDU_LATENCY(LAT), .REG_W(REG_W), .CNT_W(4)) dut_sat (
        .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .id_mdu_use(id_mdu_use), .ex_mem_read(ex_mem_read), .ex_rt(ex_rt),
        .beq_taken(beq_taken), .mdu_start(mdu_start), .pc_write(pc_write_b),
        .if_id_write(if_id_write_b), .if_id_flush(if_id_flush_b),
        .id_ex_bubble(id_ex_bubble_b), .mdu_busy(mdu_busy_b),
        .stall_cycles(stall_cycles_b), .flush_cycles(flush_cycles_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit model_load_hz();
        return ex_mem_read && (ex_rt != 0) &&
               ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
    endfunction

    function automatic bit model_stall();
        return model_load_hz() || (id_mdu_use && (cyc <= busy_until));
    endfunction

    function automatic int sat(input int v, input int maxv);
        return (v > maxv) ? maxv : v;
    endfunction

    // model advances on the active edge using the inputs of the ending cycle
    always @(posedge clk) begin
        if (reset) begin
            busy_until = -1;
            stall_cnt  = 0;
            flush_cnt  = 0;
            model_on   = 1;
        end else begin
            if (model_stall()) stall_cnt++;
            if (!model_stall() && beq_taken) flush_cnt++;
            if (mdu_start) busy_until = cyc + LAT - 1;
        end
        cyc++;
    end

    // compare process, mid-cycle
    always @(negedge clk) begin
        if (model_on) begin
            bit st, busy_e, pc_e, fl_e, bub_e;
            st     = model_stall();
            busy_e = (cyc <= busy_until);
            pc_e   = !reset && !st;
            bub_e  = !reset && st;
            fl_e   = !reset && !st && beq_taken;
            check("pc_write",       pc_write_a,     pc_e);
            check("if_id_write",    if_id_write_a,  pc_e);
            check("if_id_flush",    if_id_flush_a,  fl_e);
            check("id_ex_bubble",   id_ex_bubble_a, bub_e);
            check("mdu_busy",       mdu_busy_a,     busy_e);
            check("stall_cycles",   stall_cycles_a, sat(stall_cnt, 65535));
            check("flush_cycles",   flush_cycles_a, sat(flush_cnt, 65535));
            check("sat_pc_write",   pc_write_b,     pc_e);
            check("sat_mdu_busy",   mdu_busy_b,     busy_e);
            check("sat_stall_cnt",  stall_cycles_b, sat(stall_cnt, 15));
            check("sat_flush_cnt",  flush_cycles_b, sat(flush_cnt, 15));
        end
    end

    task automatic drive_idle();
        id_rs = '0; id_rt = '0; ex_rt = '0;
        id_uses_rt = 0; id_mdu_use = 0; ex_mem_read = 0; beq_taken = 0; mdu_start = 0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1;
        drive_idle();
        next_cycle();
        reset = 0;
    endtask

    task automatic load_use(input int rt, input int rs, input int rt_id, input bit uses);
        ex_mem_read = 1; ex_rt = REG_W'(rt); id_rs = REG_W'(rs); id_rt = REG_W'(rt_id);
        id_uses_rt = uses;
    endtask

    initial begin
        drive_idle();
        reset = 1;
        next_cycle();
        @(negedge clk);
        check("lit_reset_pc", pc_write_a, 0);
        check("lit_reset_ifid", if_id_write_a, 0);
        next_cycle();
        reset = 0;
        @(negedge clk);
        check("lit_rst_stall", stall_cycles_a, 0);
        check("lit_rst_busy", mdu_busy_a, 0);
        check("lit_idle_pc", pc_write_a, 1);

        // load-use hit lasts one cycle
        next_cycle(); load_use(5, 5, 0, 0);
        @(negedge clk);
        check("lit_lu_pc", pc_write_a, 0);
        check("lit_lu_ifid", if_id_write_a, 0);
        check("lit_lu_bubble", id_ex_bubble_a, 1);
        next_cycle(); drive_idle();
        @(negedge clk);
        check("lit_lu_after_pc", pc_write_a, 1);
        check("lit_lu_cnt", stall_cycles_a, 1);

        // $zero and rt masking
        next_cycle(); load_use(0, 0, 0, 1);
        @(negedge clk); check("lit_zero_nostall", pc_write_a, 1);
        next_cycle(); load_use(7, 3, 7, 0);
        @(negedge clk); check("lit_rt_masked", pc_write_a, 1);
        next_cycle(); load_use(7, 3, 7, 1);
        @(negedge clk); check("lit_rt_used", id_ex_bubble_a, 1);

        // taken branch
        next_cycle(); do_reset(); beq_taken = 1;
        @(negedge clk);
        check("lit_br_flush", if_id_flush_a, 1);
        check("lit_br_pc", pc_write_a, 1);
        check("lit_br_bubble", id_ex_bubble_a, 0);
        next_cycle(); drive_idle();
        @(negedge clk); check("lit_br_cnt", flush_cycles_a, 1);

        // branch vs load-use
        next_cycle(); load_use(5, 5, 0, 0); beq_taken = 1;
        @(negedge clk);
        check("lit_brlu_flush", if_id_flush_a, 0);
        check("lit_brlu_bubble", id_ex_bubble_a, 1);
        next_cycle(); ex_mem_read = 0;
        @(negedge clk); check("lit_brlu_reflush", if_id_flush_a, 1);

        // MDU single issue with a dependent consumer waiting
        next_cycle(); do_reset(); mdu_start = 1; id_mdu_use = 1;
        for (int c = 1; c <= 4; c++) begin
            next_cycle(); mdu_start = 0;
            @(negedge clk);
            check("lit_mdu_busy", mdu_busy_a, (c <= 3));
        end
        check("lit_mdu_stalls", stall_cycles_a, 3);

        // back-to-back issue extends busy through cycle 5
        next_cycle(); do_reset(); mdu_start = 1;
        for (int c = 1; c <= 6; c++) begin
            next_cycle(); mdu_start = (c == 2);
            @(negedge clk);
            check("lit_mdu_ext", mdu_busy_a, (c <= 5));
        end

        // reset while busy
        next_cycle(); mdu_start = 1; beq_taken = 1;
        next_cycle(); mdu_start = 0; reset = 1;
        next_cycle(); reset = 0; beq_taken = 0;
        @(negedge clk);
        check("lit_rstbusy_busy", mdu_busy_a, 0);
        check("lit_rstbusy_flush", flush_cycles_a, 0);

        // saturation of the narrow counter
        load_use(9, 9, 0, 0);
        repeat (20) next_cycle();
        drive_idle();
        @(negedge clk);
        check("lit_sat4", stall_cycles_b, 15);
        check("lit_sat16", stall_cycles_a, 20);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            next_cycle();
            reset       = ($urandom_range(0, 149) == 0);
            id_rs       = REG_W'($urandom_range(0, 3));
            id_rt       = REG_W'($urandom_range(0, 3));
            ex_rt       = REG_W'($urandom_range(0, 3));
            id_uses_rt  = $urandom_range(0, 1);
            id_mdu_use  = $urandom_range(0, 1);
            ex_mem_read = ($urandom_range(0, 2) == 0);
            beq_taken   = ($urandom_range(0, 3) == 0);
            mdu_start   = ($urandom_range(0, 5) == 0);
        end
        next_cycle();
        drive_idle();
        reset = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
